pd_retention_responder: RTL and testbench

- Domain-side responder for the power controller's isolation / retention / power-switch protocol (iso_en, ret_en, pse).
- Models a switchable WIDTH-bit state register inside the gated domain, plus its always-on retention shadow register.
- Clamps the domain output while isolated and models the power-up ramp.
- Returns pwr_ack to the controller and flags protocol-order violations.

---
 rtl/pd_retention_responder.sv | 73 +++++++
 tb/tb_pd_retention_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pd_retention_responder.sv
// pd_retention_responder: gated-domain state register with retention shadow, isolation clamp and power-up ramp.
module pd_retention_responder #(
  parameter int WIDTH = 16,
  parameter int PWR_UP_CYCLES = 4,
  parameter logic [WIDTH-1:0] CLAMP_VAL = '0,
  parameter logic [WIDTH-1:0] POISON_VAL = 16'hDEAD
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iso_en,
  input  logic             ret_en,
  input  logic             pse,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_out,
  output logic             pwr_ack,
  output logic             ret_valid,
  output logic             err_seq
);
  localparam int CW = $clog2(PWR_UP_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(PWR_UP_CYCLES - 1);
  typedef enum logic [1:0] {ON, OFF, RAMP} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] q_reg, ret_reg;
  logic [CW-1:0] cnt;
  logic ret_en_d, iso_en_d;
  logic rise, fall, on, pwr_loss, save, restore, load, err_now;
  assign q_out = iso_en ? CLAMP_VAL : q_reg;
  always_comb begin
    state_n = state;
    case (state)
      ON:      state_n = pse ? ON : OFF;
      OFF:     state_n = pse ? RAMP : OFF;
      RAMP:    state_n = !pse ? OFF : (cnt == LAST) ? ON : RAMP;
      default: state_n = ON;
    endcase
    rise = ret_en & ~ret_en_d;
    fall = ~ret_en & ret_en_d;
    on = state == ON;
    pwr_loss = on & ~pse;
    save = rise & on;
    restore = fall & on & ret_valid & pse;
    load = on & d_valid & ~iso_en & ~ret_en & pse;
    err_now = (pwr_loss & (~iso_en | ~ret_en)) | ((rise | fall) & ~on) | (iso_en_d & ~iso_en & ~pwr_ack);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ON;
      q_reg <= '0;
      ret_reg <= '0;
      ret_valid <= 1'b0;
      pwr_ack <= 1'b1;
      err_seq <= 1'b0;
      cnt <= '0;
      ret_en_d <= 1'b0;
      iso_en_d <= 1'b0;
    end else begin
      state <= state_n;
      ret_en_d <= ret_en;
      iso_en_d <= iso_en;
      pwr_ack <= state_n == ON;
      cnt <= (state == RAMP) ? cnt + 1'b1 : '0;
      if (pwr_loss) q_reg <= POISON_VAL;
      else if (restore) q_reg <= ret_reg;
      else if (load) q_reg <= d_in;
      if (save) begin
        ret_reg <= q_reg;
        ret_valid <= 1'b1;
      end else if (restore) ret_valid <= 1'b0;
      if (err_now) err_seq <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pd_retention_responder.sv
// tb_pd_retention_responder: scoreboard-driven scenarios for the retention responder.
module tb_pd_retention_responder;
  logic CLK = 1'b0, RST = 1'b1;
  logic iso_en = 1'b0, ret_en = 1'b0, pse = 1'b1, d_valid = 1'b0;
  logic [15:0] d_in = '0;
  logic [15:0] q_out;
  logic pwr_ack, ret_valid, err_seq;
  logic [18:0] exp_q[$];
  logic [18:0] e, obs;
  int total = 0, passed = 0, n;

  pd_retention_responder dut (
    .CLK(CLK), .RST(RST), .iso_en(iso_en), .ret_en(ret_en), .pse(pse),
    .d_in(d_in), .d_valid(d_valid), .q_out(q_out), .pwr_ack(pwr_ack),
    .ret_valid(ret_valid), .err_seq(err_seq)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; iso_en = 1'b0; ret_en = 1'b0; pse = 1'b1; d_valid = 1'b0;
    cyc();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; iso_en = 1'b0; ret_en = 1'b0; pse = 1'b1;
    exp_q.push_back({16'h0000, 1'b1, 1'b0, 1'b0});
    cyc();
    RST = 1'b0;
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL reset: got %h want %h", obs, e); else passed++;
  endtask

  task automatic test_legal_cycle();
    d_in = 16'h1234; d_valid = 1'b1;
    exp_q.push_back({16'h1234, 1'b1, 1'b0, 1'b0});
    cyc();
    d_valid = 1'b0;
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL legal_load: got %h want %h", obs, e); else passed++;
    iso_en = 1'b1; ret_en = 1'b1;
    exp_q.push_back({16'h0000, 1'b1, 1'b1, 1'b0});
    cyc();
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL legal_save: got %h want %h", obs, e); else passed++;
    pse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({16'h0000, 1'b0, 1'b1, 1'b0});
      cyc();
      e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
      if (obs !== e) $display("FAIL legal_off[%0d]: got %h want %h", i, obs, e); else passed++;
      total++;
      if (dut.q_reg !== 16'hDEAD) $display("FAIL legal_poison[%0d]: got %h want dead", i, dut.q_reg); else passed++;
    end
    pse = 1'b1; n = 0;
    do begin cyc(); n++; end while (!pwr_ack && n < 20);
    total++;
    if (n !== 5) $display("FAIL legal_ramp_edges: got %0d want 5", n); else passed++;
    ret_en = 1'b0;
    exp_q.push_back({16'h0000, 1'b1, 1'b0, 1'b0});
    cyc();
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL legal_restore: got %h want %h", obs, e); else passed++;
    iso_en = 1'b0;
    exp_q.push_back({16'h1234, 1'b1, 1'b0, 1'b0});
    cyc();
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL legal_release: got %h want %h", obs, e); else passed++;
  endtask

  task automatic test_unsafe_pd();
    do_reset();
    pse = 1'b0;
    exp_q.push_back({16'hDEAD, 1'b0, 1'b0, 1'b1});
    cyc();
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL unsafe_pd: got %h want %h", obs, e); else passed++;
    pse = 1'b1; n = 0;
    do begin cyc(); n++; end while (!pwr_ack && n < 20);
    exp_q.push_back({16'hDEAD, 1'b1, 1'b0, 1'b1});
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL unsafe_sticky: got %h want %h", obs, e); else passed++;
  endtask

  task automatic test_aborted_ramp();
    do_reset();
    iso_en = 1'b1; ret_en = 1'b1;
    cyc();
    pse = 1'b0;
    cyc();
    pse = 1'b1;
    cyc(); cyc();
    pse = 1'b0;
    exp_q.push_back({16'h0000, 1'b0, 1'b1, 1'b0});
    cyc();
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL abort_off: got %h want %h", obs, e); else passed++;
    pse = 1'b1; n = 0;
    do begin cyc(); n++; end while (!pwr_ack && n < 20);
    total++;
    if (n !== 5) $display("FAIL abort_ramp_edges: got %0d want 5", n); else passed++;
    ret_en = 1'b0;
    cyc();
    iso_en = 1'b0;
    exp_q.push_back({16'h0000, 1'b1, 1'b0, 1'b0});
    cyc();
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL abort_final: got %h want %h", obs, e); else passed++;
  endtask

  task automatic test_early_restore();
    do_reset();
    d_in = 16'h5555; d_valid = 1'b1;
    cyc();
    d_valid = 1'b0; iso_en = 1'b1; ret_en = 1'b1;
    cyc();
    pse = 1'b0;
    cyc();
    pse = 1'b1;
    cyc();
    ret_en = 1'b0;
    exp_q.push_back({16'h0000, 1'b0, 1'b1, 1'b1});
    cyc();
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL early_restore: got %h want %h", obs, e); else passed++;
    n = 0;
    do begin cyc(); n++; end while (!pwr_ack && n < 20);
    total++;
    if (dut.q_reg !== 16'hDEAD) $display("FAIL early_no_restore: got %h want dead", dut.q_reg); else passed++;
    total++;
    if (ret_valid !== 1'b1) $display("FAIL early_ret_valid: got %b want 1", ret_valid); else passed++;
  endtask

  task automatic test_load_gating();
    do_reset();
    iso_en = 1'b1; d_in = 16'hBEEF; d_valid = 1'b1;
    cyc();
    total++;
    if (dut.q_reg !== 16'h0000) $display("FAIL gate_iso: got %h want 0000", dut.q_reg); else passed++;
    d_valid = 1'b0; iso_en = 1'b0;
    cyc();
    d_valid = 1'b1;
    exp_q.push_back({16'hBEEF, 1'b1, 1'b0, 1'b0});
    cyc();
    d_valid = 1'b0;
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL gate_load: got %h want %h", obs, e); else passed++;
  endtask

  task automatic test_reset_mid_ramp();
    iso_en = 1'b1; ret_en = 1'b1;
    cyc();
    pse = 1'b0;
    cyc();
    pse = 1'b1;
    cyc(); cyc();
    total++;
    if (ret_valid !== 1'b1 || pwr_ack !== 1'b0) $display("FAIL midramp_pre: got rv=%b ack=%b want rv=1 ack=0", ret_valid, pwr_ack); else passed++;
    RST = 1'b1; iso_en = 1'b0; ret_en = 1'b0;
    exp_q.push_back({16'h0000, 1'b1, 1'b0, 1'b0});
    cyc();
    RST = 1'b0;
    e = exp_q.pop_front(); obs = {q_out, pwr_ack, ret_valid, err_seq}; total++;
    if (obs !== e) $display("FAIL midramp_reset: got %h want %h", obs, e); else passed++;
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_unsafe_pd();
    test_aborted_ramp();
    test_early_restore();
    test_load_gating();
    test_reset_mid_ramp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
